// File: rtl/sync_down_timer_pkg.sv
// Shared constants for the programmable down-timer: state encoding and default width.
package down_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN
  } state_t;

endpackage

// File: rtl/sync_down_timer_if.sv
// Control/status bundle between a sequential block and its down-timer.
interface sync_down_timer_if
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             tc;

  modport master (
    output start, load_val, en, auto_reload, abort,
    input  q, busy, tc
  );

  modport slave (
    input  start, load_val, en, auto_reload, abort,
    output q, busy, tc
  );
endinterface

// File: rtl/sync_down_timer_core.sv
// WIDTH-bit count register with clear, load and decrement, plus zero/one flags.
module down_count_core
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             is_one,
  output logic             is_zero
);

  // The caller only asserts dec for q>=2, so the subtract never borrows out.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec) begin
      q <= q - WIDTH'(1);
    end
  end

  assign is_one  = (q == WIDTH'(1));
  assign is_zero = (q == '0);

endmodule

// File: rtl/sync_down_timer.sv
// Programmable down-timer: one-shot or periodic, one-cycle terminal-count pulse.
module sync_down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  sync_down_timer_if.slave      bus
);

  state_t           state, state_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc, tc_next;
  logic [WIDTH-1:0] q;
  logic             is_one, is_zero;
  logic             core_clr, core_load, core_dec;
  logic [WIDTH-1:0] core_val;

  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .clr      (core_clr),
    .load     (core_load),
    .load_val (core_val),
    .dec      (core_dec),
    .q        (q),
    .is_one   (is_one),
    .is_zero  (is_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      reload_reg <= '0;
      tc         <= 1'b0;
    end else begin
      state      <= state_next;
      reload_reg <= reload_next;
      tc         <= tc_next;
    end
  end

  // Priority: abort > start > terminal event / decrement.
  always_comb begin
    state_next  = state;
    reload_next = reload_reg;
    tc_next     = 1'b0;
    core_clr    = 1'b0;
    core_load   = 1'b0;
    core_dec    = 1'b0;
    core_val    = bus.load_val;

    if (bus.abort) begin
      core_clr   = 1'b1;
      state_next = S_IDLE;
    end else if (bus.start) begin
      if (bus.load_val != '0) begin
        core_load   = 1'b1;
        reload_next = bus.load_val;
        state_next  = S_RUN;
      end else begin
        // Zero period expires immediately without ever entering RUN.
        core_clr   = 1'b1;
        tc_next    = 1'b1;
        state_next = S_IDLE;
      end
    end else if (state == S_RUN && bus.en) begin
      if (is_one) begin
        tc_next = 1'b1;
        if (bus.auto_reload) begin
          core_load = 1'b1;
          core_val  = reload_reg;
        end else begin
          core_clr   = 1'b1;
          state_next = S_IDLE;
        end
      end else if (!is_zero) begin
        core_dec = 1'b1;
      end
    end
  end

  assign bus.q    = q;
  assign bus.busy = (state == S_RUN);
  assign bus.tc   = tc;

endmodule
